// File: rtl/branch_predictor_tournament_param.sv
// rtl/branch_predictor_tournament_param.sv - bimodal/local/gshare/tournament direction predictor with table-init FSM

package branch_predictor_tournament_param_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_outcome_t;
endpackage

module branch_predictor_tournament_param
    import branch_predictor_tournament_param_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int PC_IDX_BITS = 10,
    parameter int LHIST_BITS  = 10,
    parameter int GHIST_BITS  = 12,
    parameter int CTR_BITS    = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_mode,
    input  logic                  i_clear,
    output logic                  o_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    input  logic [ADDR_WIDTH-1:0] i_req_target,
    output branch_outcome_t       o_req_prediction,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  branch_outcome_t       i_fb_prediction,
    input  branch_outcome_t       i_fb_outcome,
    output logic [CNT_WIDTH-1:0]  o_fb_count,
    output logic [CNT_WIDTH-1:0]  o_mispred_count
);

    localparam int MAXB_PL = (PC_IDX_BITS > LHIST_BITS) ? PC_IDX_BITS : LHIST_BITS;
    localparam int MAXB    = (MAXB_PL > GHIST_BITS) ? MAXB_PL : GHIST_BITS;
    localparam int BIM_D   = 1 << PC_IDX_BITS;
    localparam int LPHT_D  = 1 << LHIST_BITS;
    localparam int GPHT_D  = 1 << GHIST_BITS;

    localparam logic [MAXB:0] BIM_LIM  = (MAXB+1)'(BIM_D);
    localparam logic [MAXB:0] LPHT_LIM = (MAXB+1)'(LPHT_D);
    localparam logic [MAXB:0] GPHT_LIM = (MAXB+1)'(GPHT_D);

    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
    localparam logic [1:0]          WEAK_LOCAL = 2'b01;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [MAXB-1:0]         init_idx;
    logic [GHIST_BITS-1:0]   ghist;

    logic [CTR_BITS-1:0]     bim    [BIM_D];
    logic [LHIST_BITS-1:0]   lht    [BIM_D];
    logic [CTR_BITS-1:0]     lpht   [LPHT_D];
    logic [CTR_BITS-1:0]     gpht   [GPHT_D];
    logic [1:0]              choose [GPHT_D];

    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c, input logic up);
        if (up)
            return (c == '1) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [1:0] chooser_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 1'b1;
        else
            return (c == 2'b00) ? c : c - 1'b1;
    endfunction

    // Request path: combinational read of current (pre-update) table state
    logic [PC_IDX_BITS-1:0] req_pcidx;
    logic [LHIST_BITS-1:0]  req_lhist;
    logic [GHIST_BITS-1:0]  req_gidx;
    logic                   p_bim;
    logic                   p_loc;
    logic                   p_gsh;
    logic                   p_tour;
    logic                   pred_bit;

    assign req_pcidx = i_req_pc[PC_IDX_BITS+1:2];
    assign req_lhist = lht[req_pcidx];
    assign req_gidx  = i_req_pc[GHIST_BITS+1:2] ^ ghist;
    assign p_bim     = bim[req_pcidx][CTR_BITS-1];
    assign p_loc     = lpht[req_lhist][CTR_BITS-1];
    assign p_gsh     = gpht[req_gidx][CTR_BITS-1];
    assign p_tour    = choose[ghist][1] ? p_gsh : p_loc;

    always_comb begin
        pred_bit = 1'b0;
        if (o_ready) begin
            case (i_mode)
                2'd0: pred_bit = p_bim;
                2'd1: pred_bit = p_loc;
                2'd2: pred_bit = p_gsh;
                2'd3: pred_bit = p_tour;
            endcase
        end
    end

    assign o_req_prediction = pred_bit ? TAKEN : NOT_TAKEN;

    // Feedback path
    logic [PC_IDX_BITS-1:0] fb_pcidx;
    logic [LHIST_BITS-1:0]  fb_lhist;
    logic [GHIST_BITS-1:0]  fb_gidx;
    logic                   fb_taken;
    logic                   fb_en;
    logic                   fb_loc_pred;
    logic                   fb_gsh_pred;
    logic [1:0]             ch_cur;
    logic [1:0]             ch_next;

    assign fb_pcidx    = i_fb_pc[PC_IDX_BITS+1:2];
    assign fb_lhist    = lht[fb_pcidx];
    assign fb_gidx     = i_fb_pc[GHIST_BITS+1:2] ^ ghist;
    assign fb_taken    = (i_fb_outcome == TAKEN);
    assign fb_en       = o_ready & i_fb_valid;
    assign fb_loc_pred = lpht[fb_lhist][CTR_BITS-1];
    assign fb_gsh_pred = gpht[fb_gidx][CTR_BITS-1];
    assign ch_cur      = choose[ghist];
    assign ch_next     = (fb_loc_pred != fb_gsh_pred) ? chooser_step(ch_cur, fb_gsh_pred == fb_taken)
                                                      : ch_cur;

    logic [MAXB:0] init_ext;
    logic          init_bim;
    logic          init_lpht;
    logic          init_gpht;

    assign init_ext  = {1'b0, init_idx};
    assign init_bim  = init_ext < BIM_LIM;
    assign init_lpht = init_ext < LPHT_LIM;
    assign init_gpht = init_ext < GPHT_LIM;

    // Tables carry no reset; the INIT sweep is what gives them defined contents
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            if (init_bim) begin
                bim[init_idx[PC_IDX_BITS-1:0]] <= WEAK_NT;
                lht[init_idx[PC_IDX_BITS-1:0]] <= '0;
            end
            if (init_lpht)
                lpht[init_idx[LHIST_BITS-1:0]] <= WEAK_NT;
            if (init_gpht) begin
                gpht[init_idx[GHIST_BITS-1:0]]   <= WEAK_NT;
                choose[init_idx[GHIST_BITS-1:0]] <= WEAK_LOCAL;
            end
        end else if (fb_en) begin
            bim[fb_pcidx]  <= ctr_step(bim[fb_pcidx], fb_taken);
            lpht[fb_lhist] <= ctr_step(lpht[fb_lhist], fb_taken);
            gpht[fb_gidx]  <= ctr_step(gpht[fb_gidx], fb_taken);
            choose[ghist]  <= ch_next;
            lht[fb_pcidx]  <= {fb_lhist[LHIST_BITS-2:0], fb_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_INIT;
            init_idx        <= '0;
            ghist           <= '0;
            o_ready         <= 1'b0;
            o_fb_count      <= '0;
            o_mispred_count <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == '1) begin
                        state   <= ST_RUN;
                        o_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        state    <= ST_INIT;
                        init_idx <= '0;
                        ghist    <= '0;
                        o_ready  <= 1'b0;
                    end else if (fb_en) begin
                        ghist <= {ghist[GHIST_BITS-2:0], fb_taken};
                    end
                end
            endcase
            // Statistics survive i_clear; only rst zeroes them
            if (fb_en) begin
                if (o_fb_count != '1)
                    o_fb_count <= o_fb_count + 1'b1;
                if ((i_fb_prediction != i_fb_outcome) && (o_mispred_count != '1))
                    o_mispred_count <= o_mispred_count + 1'b1;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{i_req_valid, i_req_target, i_req_pc, i_fb_pc};

endmodule

// File: tb/tb_branch_predictor_tournament_param.sv
// tb/tb_branch_predictor_tournament_param.sv - directed self-checking bench for the tournament predictor

module tb_branch_predictor_tournament_param;
    import branch_predictor_tournament_param_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      i_mode = 2'd0;
    logic            i_clear = 1'b0;
    logic            o_ready;
    logic            i_req_valid = 1'b0;
    logic [31:0]     i_req_pc = '0;
    logic [31:0]     i_req_target = '0;
    branch_outcome_t o_req_prediction;
    logic            i_fb_valid = 1'b0;
    logic [31:0]     i_fb_pc = '0;
    branch_outcome_t i_fb_prediction = NOT_TAKEN;
    branch_outcome_t i_fb_outcome = NOT_TAKEN;
    logic [31:0]     o_fb_count;
    logic [31:0]     o_mispred_count;

    logic            s_ready;
    branch_outcome_t s_pred;
    logic            s_fb_valid = 1'b0;
    logic [31:0]     s_fb_pc = '0;
    branch_outcome_t s_fb_prediction = NOT_TAKEN;
    branch_outcome_t s_fb_outcome = NOT_TAKEN;
    logic [3:0]      s_fb_count;
    logic [3:0]      s_mispred_count;

    int checks = 0;
    int failures = 0;
    int exp_fb = 0;
    int exp_mis = 0;

    always #5 clk = ~clk;

    branch_predictor_tournament_param u_dut (
        .clk              (clk),
        .rst              (rst),
        .i_mode           (i_mode),
        .i_clear          (i_clear),
        .o_ready          (o_ready),
        .i_req_valid      (i_req_valid),
        .i_req_pc         (i_req_pc),
        .i_req_target     (i_req_target),
        .o_req_prediction (o_req_prediction),
        .i_fb_valid       (i_fb_valid),
        .i_fb_pc          (i_fb_pc),
        .i_fb_prediction  (i_fb_prediction),
        .i_fb_outcome     (i_fb_outcome),
        .o_fb_count       (o_fb_count),
        .o_mispred_count  (o_mispred_count)
    );

    branch_predictor_tournament_param #(
        .ADDR_WIDTH  (32),
        .PC_IDX_BITS (4),
        .LHIST_BITS  (4),
        .GHIST_BITS  (4),
        .CTR_BITS    (2),
        .CNT_WIDTH   (4)
    ) u_small (
        .clk              (clk),
        .rst              (rst),
        .i_mode           (2'd0),
        .i_clear          (1'b0),
        .o_ready          (s_ready),
        .i_req_valid      (1'b0),
        .i_req_pc         (32'h0),
        .i_req_target     (32'h0),
        .o_req_prediction (s_pred),
        .i_fb_valid       (s_fb_valid),
        .i_fb_pc          (s_fb_pc),
        .i_fb_prediction  (s_fb_prediction),
        .i_fb_outcome     (s_fb_outcome),
        .o_fb_count       (s_fb_count),
        .o_mispred_count  (s_mispred_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic [31:0] pc, output branch_outcome_t p);
        i_req_pc    = pc;
        i_req_valid = 1'b1;
        #1;
        p = o_req_prediction;
    endtask

    // Called at a negedge in RUN; applies one feedback over the next posedge
    task automatic feedback(input logic [31:0] pc, input branch_outcome_t pred, input branch_outcome_t outc);
        i_fb_valid      = 1'b1;
        i_fb_pc         = pc;
        i_fb_prediction = pred;
        i_fb_outcome    = outc;
        exp_fb++;
        if (pred != outc) exp_mis++;
        @(negedge clk);
        i_fb_valid = 1'b0;
    endtask

    // Counts sampled cycles with o_ready low, starting from the current negedge
    task automatic count_init(output int cycles, output int bad_pred);
        cycles   = 0;
        bad_pred = 0;
        while (!o_ready && cycles < 10000) begin
            cycles++;
            if (o_req_prediction !== NOT_TAKEN) bad_pred++;
            @(negedge clk);
        end
    endtask

    task automatic run_loop(input logic [1:0] mode, output int mis_last40);
        branch_outcome_t p;
        branch_outcome_t outc;
        i_mode     = mode;
        mis_last40 = 0;
        for (int i = 0; i < 400; i++) begin
            outc = ((i % 4) == 3) ? NOT_TAKEN : TAKEN;
            predict(32'h800, p);
            if (i >= 360 && p != outc) mis_last40++;
            feedback(32'h800, p, outc);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int mis;
        branch_outcome_t p;
        branch_outcome_t outc;

        // Reset state
        i_mode   = 2'd3;
        i_req_pc = 32'h400;
        repeat (3) @(negedge clk);
        check("reset_ready", o_ready, 0);
        check("reset_fb_count", o_fb_count, 0);
        check("reset_mis_count", o_mispred_count, 0);
        check("reset_pred", o_req_prediction, NOT_TAKEN);

        // INIT length, with 5 feedbacks that must be dropped
        rst = 1'b0;
        cyc = 0;
        bad = 0;
        while (!o_ready && cyc < 10000) begin
            cyc++;
            if (o_req_prediction !== NOT_TAKEN) bad++;
            i_fb_valid      = (cyc <= 5);
            i_fb_pc         = 32'h400;
            i_fb_prediction = NOT_TAKEN;
            i_fb_outcome    = TAKEN;
            @(negedge clk);
        end
        i_fb_valid = 1'b0;
        check("init_cycles", cyc, 4096);
        check("init_pred_nt", bad, 0);
        check("init_ready", o_ready, 1);
        check("init_fb_dropped", o_fb_count, 0);
        check("init_mis_dropped", o_mispred_count, 0);

        // Statistics: 10 feedbacks, 3 mispredicted
        for (int i = 0; i < 10; i++) begin
            outc = (i % 2 == 0) ? TAKEN : NOT_TAKEN;
            p    = (i == 2 || i == 5 || i == 8) ? ((outc == TAKEN) ? NOT_TAKEN : TAKEN) : outc;
            feedback(32'hC00, p, outc);
        end
        check("stats_fb_count", o_fb_count, 10);
        check("stats_mis_count", o_mispred_count, 3);

        // Small instance: 4-bit counters saturate
        check("small_ready", s_ready, 1);
        for (int i = 0; i < 20; i++) begin
            s_fb_valid      = 1'b1;
            s_fb_pc         = 32'(i * 4);
            s_fb_outcome    = NOT_TAKEN;
            s_fb_prediction = (i < 5) ? TAKEN : NOT_TAKEN;
            @(negedge clk);
        end
        s_fb_valid = 1'b0;
        check("small_fb_sat", s_fb_count, 15);
        check("small_mis_count", s_mispred_count, 5);

        // Bimodal saturation at PC 0x400
        i_mode = 2'd0;
        predict(32'h400, p);
        check("bim_initial_nt", p, NOT_TAKEN);
        feedback(32'h400, TAKEN, TAKEN);
        feedback(32'h400, TAKEN, TAKEN);
        predict(32'h400, p);
        check("bim_tt_taken", p, TAKEN);
        feedback(32'h400, TAKEN, NOT_TAKEN);
        predict(32'h400, p);
        check("bim_ttn_taken", p, TAKEN);
        feedback(32'h400, TAKEN, NOT_TAKEN);
        predict(32'h400, p);
        check("bim_ttnn_nt", p, NOT_TAKEN);
        for (int i = 0; i < 5; i++) feedback(32'h400, TAKEN, TAKEN);
        feedback(32'h400, TAKEN, NOT_TAKEN);
        predict(32'h400, p);
        check("bim_sat_taken", p, TAKEN);

        // Local history: alternating T/N at PC 0x400
        i_mode = 2'd1;
        mis    = 0;
        for (int i = 0; i < 60; i++) begin
            outc = (i % 2 == 0) ? TAKEN : NOT_TAKEN;
            predict(32'h400, p);
            if (i >= 40 && p != outc) mis++;
            feedback(32'h400, p, outc);
        end
        check("local_alt_last20", mis, 0);

        // Loop branch TTTN: gshare and tournament learn it, bimodal cannot
        run_loop(2'd2, mis);
        check("gshare_loop_last40", mis, 0);
        run_loop(2'd3, mis);
        check("tour_loop_last40", mis, 0);
        run_loop(2'd0, mis);
        check("bim_loop_ge10", (mis >= 10), 1);

        // Clear mid-operation
        for (int i = 0; i < 3; i++) feedback(32'h400, TAKEN, TAKEN);
        predict(32'h400, p);
        check("pre_clear_taken", p, TAKEN);
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        check("clear_ready_low", o_ready, 0);
        cyc = 0;
        bad = 0;
        while (!o_ready && cyc < 10000) begin
            cyc++;
            if (o_req_prediction !== NOT_TAKEN) bad++;
            i_clear = (cyc >= 50 && cyc < 53);
            @(negedge clk);
        end
        i_clear = 1'b0;
        check("clear_init_cycles", cyc, 4096);
        check("clear_pred_nt", bad, 0);
        predict(32'h400, p);
        check("post_clear_nt", p, NOT_TAKEN);
        check("post_clear_fb_count", o_fb_count, 32'(exp_fb));
        check("post_clear_mis_count", o_mispred_count, 32'(exp_mis));

        // Reset at INIT cycle 100 restarts the sweep
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midinit_rst_ready", o_ready, 0);
        check("midinit_rst_fb", o_fb_count, 0);
        @(negedge clk);
        rst = 1'b0;
        count_init(cyc, bad);
        check("rst_restart_cycles", cyc, 4096);
        check("rst_restart_pred_nt", bad, 0);
        check("rst_restart_ready", o_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
